// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Owner state encoding: which port (if any) was granted last cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    // Port indices
    localparam logic c_P0 = 1'b0;
    localparam logic c_P1 = 1'b1;

    // Default limit on back-to-back grants while the other port waits
    localparam int c_BURST_MAX_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester ports and Data_Memory bus of the data-memory arbiter.
//            slave  = arbiter side, master = requester/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             p0_req;
    logic             p0_we;
    logic [WIDTH-1:0] p0_addr;
    logic [WIDTH-1:0] p0_wdata;
    logic             p0_ready;
    logic             p0_rvalid;
    logic [WIDTH-1:0] p0_rdata;
    logic             p0_stall;

    logic             p1_req;
    logic             p1_we;
    logic [WIDTH-1:0] p1_addr;
    logic [WIDTH-1:0] p1_wdata;
    logic             p1_ready;
    logic             p1_rvalid;
    logic [WIDTH-1:0] p1_rdata;

    logic [WIDTH-1:0] mem_A;
    logic [WIDTH-1:0] mem_WD;
    logic             mem_WE;
    logic [WIDTH-1:0] mem_RD;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_ready, p0_rvalid, p0_rdata, p0_stall,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ready, p1_rvalid, p1_rdata,
        output mem_A, mem_WD, mem_WE,
        input  mem_RD
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_ready, p0_rvalid, p0_rdata, p0_stall,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ready, p1_rvalid, p1_rdata,
        input  mem_A, mem_WD, mem_WE,
        output mem_RD
    );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant2
// Brief    : Combinational 2-way round-robin grant with a burst-length
//            override so the current owner cannot starve the other port.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant2
    import dmem_arbiter_pkg::*;
#(
    parameter int BURST_MAX = c_BURST_MAX_DEFAULT,
    parameter int CNT_W     = 3
) (
    input  logic [1:0]       i_req,
    input  owner_t           i_state,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_last,
    output logic [1:0]       o_gnt
);

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(BURST_MAX);

    // Owner keeps the port until its burst is spent and the other side waits
    always_comb begin
        o_gnt = 2'b00;
        case (i_state)
            OWN0: begin
                if (i_req[0] && ((i_cnt < c_LIMIT) || !i_req[1])) o_gnt = 2'b01;
                else if (i_req[1])                                 o_gnt = 2'b10;
            end
            OWN1: begin
                if (i_req[1] && ((i_cnt < c_LIMIT) || !i_req[0])) o_gnt = 2'b10;
                else if (i_req[0])                                 o_gnt = 2'b01;
            end
            default: begin
                // Tie goes to the port not served last
                if (i_req == 2'b11) o_gnt = i_last ? 2'b01 : 2'b10;
                else                o_gnt = i_req;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the single-port Data_Memory between the MEM stage (port 0)
//            and the loader/debug DMA (port 1). One access per cycle, read
//            data returned registered one cycle after the grant.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = c_BURST_MAX_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    dmem_arbiter_if.slave bus
);

    localparam int                 c_CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BURST_MAX);

    owner_t             r_state;
    owner_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_last;
    logic               w_last_nxt;

    logic [1:0]         w_req;
    logic [1:0]         w_gnt;
    logic               w_any;
    logic               w_sel;
    logic               w_we;

    logic               r_rvalid;
    logic               r_rd_sel;
    logic [WIDTH-1:0]   r_p0_rdata;
    logic [WIDTH-1:0]   r_p1_rdata;

    assign w_req = {bus.p1_req, bus.p0_req};

    rr_grant2 #(
        .BURST_MAX (BURST_MAX),
        .CNT_W     (c_CNT_W)
    ) u_grant (
        .i_req   (w_req),
        .i_state (r_state),
        .i_cnt   (r_cnt),
        .i_last  (r_last),
        .o_gnt   (w_gnt)
    );

    assign w_any = |w_gnt;
    // Port 1 only when it holds the grant; idle bus shows port 0's values
    assign w_sel = w_gnt[1] ? c_P1 : c_P0;
    assign w_we  = (w_sel == c_P1) ? bus.p1_we : bus.p0_we;

    assign bus.mem_A  = (w_sel == c_P1) ? bus.p1_addr  : bus.p0_addr;
    assign bus.mem_WD = (w_sel == c_P1) ? bus.p1_wdata : bus.p0_wdata;
    // Reset cycle must never commit a write
    assign bus.mem_WE = w_any & w_we & ~RST;

    assign bus.p0_ready = w_gnt[0];
    assign bus.p1_ready = w_gnt[1];
    assign bus.p0_stall = bus.p0_req & ~w_gnt[0];

    assign bus.p0_rvalid = r_rvalid & (r_rd_sel == c_P0);
    assign bus.p1_rvalid = r_rvalid & (r_rd_sel == c_P1);
    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_rdata  = r_p1_rdata;

    // Next owner, burst count and last-served port from this cycle's grant
    always_comb begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_last_nxt  = r_last;
        if (w_any) begin
            w_state_nxt = (w_sel == c_P1) ? OWN1 : OWN0;
            w_last_nxt  = w_sel;
            if (w_state_nxt == r_state)
                w_cnt_nxt = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);
            else
                w_cnt_nxt = c_CNT_W'(1);
        end
    end

    // Owner state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= c_P1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Capture read data at the granting edge; rvalid pulses for one cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rvalid   <= 1'b0;
            r_rd_sel   <= c_P0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            r_rvalid <= w_any & ~w_we;
            if (w_any && !w_we) begin
                r_rd_sel <= w_sel;
                if (w_sel == c_P1) r_p1_rdata <= bus.mem_RD;
                else               r_p0_rdata <= bus.mem_RD;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a behavioural memory
//            and arbitration reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_BMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(32)) bus ();

    dmem_arbiter #(.WIDTH(32), .BURST_MAX(c_BMAX)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // Behavioural Data_Memory: asynchronous read, write at the clock edge
    logic [31:0] ram [0:255];
    assign bus.mem_RD = ram[bus.mem_A[7:0]];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_owner;
    int          m_run;
    int          m_last;
    bit          m_known = 1'b0;
    bit          e_rvalid [2];
    logic [31:0] e_rdata  [2];
    int          last_g;
    logic        o_ready0, o_ready1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input bit r0, input bit r1);
        bit rq [2];
        int o;
        rq[0] = r0;
        rq[1] = r1;
        if (!r0 && !r1) return -1;
        if (m_owner < 0) begin
            if (r0 && r1) return 1 - m_last;
            return r0 ? 0 : 1;
        end
        o = 1 - m_owner;
        if (rq[m_owner] && (m_run < c_BMAX || !rq[o])) return m_owner;
        if (rq[o]) return o;
        return -1;
    endfunction

    // One clock cycle: drive, check at the falling edge, commit at the rising edge
    task automatic step(input bit r, input bit r0, input bit w0, input logic [31:0] a0,
                        input logic [31:0] d0, input bit r1, input bit w1,
                        input logic [31:0] a1, input logic [31:0] d1);
        int          g;
        bit          gw;
        logic [31:0] ga, gd, rd_val;
        rst = r;
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
        @(negedge clk);
        o_ready0 = bus.p0_ready;
        o_ready1 = bus.p1_ready;
        if (m_known) begin
            chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(e_rvalid[0]));
            chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(e_rvalid[1]));
            chk("p0_rdata", bus.p0_rdata, e_rdata[0]);
            chk("p1_rdata", bus.p1_rdata, e_rdata[1]);
        end
        g  = r ? -1 : model_grant(r0, r1);
        gw = (g == 1) ? w1 : w0;
        ga = (g == 1) ? a1 : a0;
        gd = (g == 1) ? d1 : d0;
        rd_val = ram[ga[7:0]];
        if (r) begin
            chk("mem_WE_rst", 32'(bus.mem_WE), 32'd0);
        end else begin
            chk("p0_ready", 32'(bus.p0_ready), 32'(g == 0));
            chk("p1_ready", 32'(bus.p1_ready), 32'(g == 1));
            chk("p0_stall", 32'(bus.p0_stall), 32'(r0 && g != 0));
            chk("mem_WE", 32'(bus.mem_WE), 32'(g >= 0 && gw));
            chk("mem_A", bus.mem_A, ga);
            chk("mem_WD", bus.mem_WD, gd);
        end
        last_g = g;
        @(posedge clk);
        #1;
        e_rvalid[0] = 1'b0;
        e_rvalid[1] = 1'b0;
        if (r) begin
            m_owner = -1; m_run = 0; m_last = 1;
            e_rdata[0] = '0; e_rdata[1] = '0;
            m_known = 1'b1;
        end else if (g >= 0) begin
            if (gw) ram[ga[7:0]] = gd;
            else begin
                e_rvalid[g] = 1'b1;
                e_rdata[g]  = rd_val;
            end
            m_run   = (g == m_owner) ? ((m_run < c_BMAX) ? m_run + 1 : m_run) : 1;
            m_owner = g;
            m_last  = g;
        end else begin
            m_owner = -1;
            m_run   = 0;
        end
    endtask

    initial begin
        logic [8:0]  pat;
        bit          pr [2];
        bit          pw [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        bit          rr;

        for (int i = 0; i < 256; i++) ram[i] = 32'(i) * 32'd3 + 32'h100;
        ram[5] = 32'hA5;
        ram[7] = 32'h0;
        rst = 1'b1;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
        @(posedge clk);
        #1;

        // Reset, then a lone port-0 read of address 5
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 5, 0, 0, 0, 0, 0);
        chk("p0_ready_solo", 32'(o_ready0), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("p0_rdata_A5", bus.p0_rdata, 32'hA5);

        // First-cycle tie after reset, then burst fairness 0,0,0,0,1,1,1,1,0
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        pat = 9'b011110000;
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 1, 0, 1, 0, 2, 0);
            chk("burst_p1_ready", 32'(o_ready1), 32'(pat[i]));
            chk("burst_p0_ready", 32'(o_ready0), 32'(!pat[i]));
        end

        // Write by port 1 then read-after-write by port 0
        step(0, 0, 0, 0, 0, 1, 1, 7, 32'hDEAD_BEEF);
        step(0, 1, 0, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_rdata", bus.p0_rdata, 32'hDEAD_BEEF);

        // Port 1 alone, 10 back-to-back reads, counter saturates
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 32'(20 + i), 0);
            chk("solo_p1_ready", 32'(o_ready1), 32'd1);
        end
        chk("cnt_sat", 32'(dut.r_cnt), 32'd4);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during port 0's third burst read
        step(0, 1, 0, 3, 0, 0, 0, 0, 0);
        step(0, 1, 0, 4, 0, 0, 0, 0, 0);
        step(1, 1, 0, 5, 0, 0, 0, 0, 0);
        chk("rst_state_idle", 32'(dut.r_state), 32'd0);
        chk("rst_cnt_zero", 32'(dut.r_cnt), 32'd0);
        step(0, 1, 0, 8, 0, 1, 0, 9, 0);
        chk("rst_tie_p0", 32'(o_ready0), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; requests held until granted or withdrawn
        pr[0] = 0; pr[1] = 0;
        pw[0] = 0; pw[1] = 0;
        pa[0] = 0; pa[1] = 0;
        pd[0] = 0; pd[1] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pr[p]) begin
                    if ($urandom_range(2) != 0) begin
                        pr[p] = 1'b1;
                        pw[p] = ($urandom_range(2) == 0);
                        pa[p] = 32'($urandom_range(15));
                        pd[p] = $urandom;
                    end
                end else if ($urandom_range(7) == 0) begin
                    pr[p] = 1'b0;
                end
            end
            rr = ($urandom_range(39) == 0);
            step(rr, pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
            if (last_g >= 0) pr[last_g] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port Data_Memory between two requesters: port 0 is the pipeline MEM stage and port 1 is the loader/debug DMA.
- Grants at most one access per cycle and drives the memory's A/WD/WE.
- Registers read data and returns it one cycle later.
- Fair round-robin with a bounded burst length, so neither port can starve the other.

Parameters:
- WIDTH, 32, data and address width (matches Data_Memory).
- BURST_MAX, 4, max consecutive grants to one port while the other port is requesting.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- p0_req  in  1  port 0 access request (held until p0_ready).
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  WIDTH  port 0 word address.
- p0_wdata  in  WIDTH  port 0 write data.
- p0_ready  out  1  port 0 access granted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  WIDTH  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ready, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_A  out  WIDTH  to Data_Memory A.
- mem_WD  out  WIDTH  to Data_Memory WD.
- mem_WE  out  1  to Data_Memory WE.
- mem_RD  in  WIDTH  from Data_Memory RD (asynchronous read).
- p0_stall  out  1  p0_req & ~p0_ready; feeds the hazard unit.

Behaviour:
- Clock/reset: one clock, CLK; reset RST is synchronous and active-high.
- State: owner FSM {IDLE, OWN0, OWN1}; burst counter cnt (0..BURST_MAX, saturating); last bit (last-served port).
- Reset values: state IDLE, cnt 0, last 1 (port 0 wins first tie). p*_rvalid 0, p*_rdata 0, rd_sel 0.
- Reset is higher priority than any request. mem_WE is 0 in the reset cycle.
- Grant (combinational, at most one of p0_ready/p1_ready high):
  - IDLE: if one req, grant it. If both, grant ~last.
  - OWNx: grant x if req_x and (cnt < BURST_MAX or !req_other). Otherwise grant other if req_other.
  - No req: no grant.
- Next state:
  - Granted port g: state OWNg; last <= g.
  - cnt <= (g == current owner) ? sat(cnt+1) : 1.
  - No grant: IDLE, cnt 0.
- Memory drive:
  - mem_A/mem_WD are muxed from the granted port. With no grant, hold the port 0 values.
  - mem_WE = grant & granted port's we.
  - Write commits at the same edge.
- Read return:
  - Granted read in cycle N → p*_rvalid = 1 in cycle N+1 for that port only.
  - p*_rdata = mem_RD captured at the end of cycle N.
  - rvalid is a one-cycle pulse. rdata holds its value until the next read for that port.
  - Writes never raise rvalid.
- Read-after-write, same address, consecutive cycles: the read returns the new data, because the write committed at the prior edge.
- Requesters must hold req/we/addr/wdata stable until ready. Dropping req before ready is legal and withdraws the request.
- Addresses ≥ DEPTH are passed through unchecked; Data_Memory behaviour governs.
- Burst limit: after BURST_MAX consecutive grants to x with the other port requesting, the next grant goes to the other port. The previous owner then waits at least one cycle.
- Reset mid-burst: the next cycle is IDLE with cnt 0. A read granted in the reset cycle produces no rvalid.

Decomposition:
- Shared package:
  - owner state encoding (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2).
  - port index constants P0 = 1'b0, P1 = 1'b1.
  - BURST_MAX default.
- One natural sub-module: rr_grant2, the combinational 2-way round-robin grant with burst override. Inputs: req[1:0], state, cnt, last. Output: gnt[1:0].
- The FSM, counter and read-return registers stay in dmem_arbiter.

Test Plan:
- After reset: only p0_req, read addr 5 (RAM[5] = 32'hA5) → p0_ready same cycle, next cycle p0_rvalid = 1 with p0_rdata = 32'hA5; p0_stall = 0.
- First-cycle tie: both req from IDLE right after reset → p0 granted (last = 1), p1_ready = 0, p0_stall = 0. Next cycle p1 is granted only after the burst limit or p0 drops.
- Burst fairness: p0 and p1 continuously request reads, BURST_MAX = 4 → grant pattern 0,0,0,0,1,1,1,1,0…; p0_stall high exactly on p1 cycles.
- Write then read: p1 writes 32'hDEAD_BEEF to addr 7 in cycle N; p0 reads addr 7 in N+1 → p0_rdata = 32'hDEAD_BEEF in N+2; mem_WE high only in N.
- Solo owner past limit: p1 alone issues 10 consecutive reads → granted all 10 back-to-back, cnt saturates at 4, no bubbles.
- Reset mid-burst: assert RST during p0's 3rd burst read → next cycle p0_rvalid = 0, state IDLE, cnt 0. After release, both req → p0 wins.
